// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and recorder state encoding
package audio_pkg;

  // PCM sample width shared with the microphone and I2S blocks
  localparam int SAMPLE_W = 18;

  // Recorder/player FSM encoding, visible on the STATE port
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REC   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/audio_rec_ctrl.sv
// rtl/audio_rec_ctrl.sv - record microphone samples to memory and play them back to I2S
module audio_rec_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REC,
  input  logic                PLAY,
  input  logic                STOP,
  input  logic                MIC_DONE,
  input  logic [SAMPLE_W-1:0] MIC_DATA,
  output logic                MIC_ENABLE,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [SAMPLE_W-1:0] MEM_WDATA,
  input  logic [SAMPLE_W-1:0] MEM_RDATA,
  output logic                SPK_VALID,
  input  logic                SPK_READY,
  output logic [SAMPLE_W-1:0] SPK_DATA,
  output logic                BUSY,
  output logic [2:0]          STATE,
  output logic [ADDR_W:0]     LEN
);

  import audio_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [1:0]        rst_sync;
  logic              run;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W:0]   idx_nxt;
  logic              full;
  logic              last;
  logic              rec_go;
  logic              play_go;

  // Reset release is retimed so the FSM never leaves IDLE on a partial first cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run     = rst_sync[1];
  assign full    = (wr_cnt == DEPTH_V);
  assign idx_nxt = {1'b0, rd_idx} + ONE_V;
  assign last    = (idx_nxt == LEN);
  // REC wins over a simultaneous PLAY; PLAY with nothing recorded is dropped
  assign rec_go  = run && REC;
  assign play_go = run && PLAY && !REC && (LEN != '0);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; STOP overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rec_go) begin
          state_nxt = ST_REC;
        end else if (play_go) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_REC: begin
        // Leave only after the final write cycle has been issued
        if (STOP || full) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt = STOP ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = STOP ? ST_IDLE : ST_OUT;
      end
      ST_OUT: begin
        if (STOP) begin
          state_nxt = ST_IDLE;
        end else if (SPK_READY) begin
          state_nxt = last ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    MIC_ENABLE = (state == ST_REC) && !full;
    SPK_VALID  = (state == ST_OUT);
    BUSY       = (state != ST_IDLE);
    STATE      = state;
  end

  // Counters, memory port and speaker data register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_cnt    <= '0;
      rd_idx    <= '0;
      LEN       <= '0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      SPK_DATA  <= '0;
    end else begin
      MEM_WE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rec_go) begin
            wr_cnt <= '0;
            LEN    <= '0;
          end else if (play_go) begin
            rd_idx   <= '0;
            MEM_ADDR <= '0;
          end
        end
        ST_REC: begin
          // A strobe coinciding with STOP or a full buffer is dropped
          if (STOP) begin
            LEN <= wr_cnt;
          end else if (full) begin
            LEN <= DEPTH_V;
          end else if (MIC_DONE) begin
            MEM_WE    <= 1'b1;
            MEM_ADDR  <= wr_cnt[ADDR_W-1:0];
            MEM_WDATA <= MIC_DATA;
            wr_cnt    <= wr_cnt + ONE_V;
          end
        end
        ST_LOAD: begin
          if (!STOP) begin
            SPK_DATA <= MEM_RDATA;
          end
        end
        ST_OUT: begin
          // STOP beats READY, so an aborted sample is not advanced past
          if (!STOP && SPK_READY && !last) begin
            rd_idx   <= idx_nxt[ADDR_W-1:0];
            MEM_ADDR <= idx_nxt[ADDR_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
